// File: rtl/mcpu_mem_responder.sv
// MCPU external-bus memory target: 2**AW x DW RAM with a byte-parallel
// program loader that holds the CPU in reset while the RAM is preloaded.
module mcpu_mem_responder #(
  parameter int AW = 6,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] adress,
  input  logic          oe,
  input  logic          we,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  input  logic          ld_done,
  output logic          ld_ready,
  output logic          cpu_hold,
  output logic [AW-1:0] ld_ptr,
  output logic          busy_err
);

  localparam int DEPTH = 2 ** AW;
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          hold_q;
  logic          err_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic run;
  logic ld_acc;
  logic cpu_wr;

  assign run      = (state_q == RUN);
  assign ld_ready = (state_q == LOAD);
  assign ld_acc   = ld_ready & ld_valid;
  assign cpu_wr   = run & we;

  // Zero-latency read: the CPU samples datain at the edge ending oe.
  assign rdata    = (run & oe) ? mem_q[adress] : '0;

  assign cpu_hold = hold_q;
  assign ld_ptr   = ptr_q;
  assign busy_err = err_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (ld_acc) begin
      ptr_d = ptr_q + 1'b1;
    end
    if (ld_start) begin
      state_d = LOAD;
      ptr_d   = '0;
    end else if (ld_ready && (ld_done || (ld_acc && ptr_q == LAST))) begin
      state_d = RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      hold_q  <= 1'b1;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      // Hold rises as soon as a load begins, falls one edge after RUN starts.
      hold_q  <= (state_q != RUN) | (state_d != RUN);
      if (!run && (oe || we)) begin
        err_q <= 1'b1;
      end
      if (ld_acc) begin
        mem_q[ptr_q] <= ld_data;
      end else if (cpu_wr) begin
        mem_q[adress] <= wdata;
      end
    end
  end

endmodule

// File: tb/tb_mcpu_mem_responder.sv
// Bench for mcpu_mem_responder: directed table, loader sequences and
// randomized traffic checked against a behavioural memory model.
module tb_mcpu_mem_responder;

  localparam int AW = 6;
  localparam int DW = 8;
  localparam int DEPTH = 64;
  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_RUN = 2;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] adress;
  logic          oe;
  logic          we;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          ld_start;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_done;
  logic          ld_ready;
  logic          cpu_hold;
  logic [AW-1:0] ld_ptr;
  logic          busy_err;

  mcpu_mem_responder #(.AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .adress   (adress),
    .oe       (oe),
    .we       (we),
    .wdata    (wdata),
    .rdata    (rdata),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_done  (ld_done),
    .ld_ready (ld_ready),
    .cpu_hold (cpu_hold),
    .ld_ptr   (ld_ptr),
    .busy_err (busy_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  int m_mode;
  int m_ptr;
  int m_hold;
  int m_err;
  int m_mem [DEPTH];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    int old_mode;
    bit acc;
    old_mode = m_mode;
    acc = 1'b0;
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_ptr  = 0;
      m_hold = 1;
      m_err  = 0;
      foreach (m_mem[i]) m_mem[i] = 0;
    end else begin
      if (old_mode != M_RUN && (oe || we)) m_err = 1;
      if (old_mode == M_RUN && we) m_mem[adress] = wdata;
      if (old_mode == M_LOAD && ld_valid) begin
        m_mem[m_ptr] = ld_data;
        acc = 1'b1;
      end
      if (ld_start) begin
        m_mode = M_LOAD;
        m_ptr  = 0;
      end else begin
        if (acc) m_ptr = (m_ptr + 1) % DEPTH;
        if (old_mode == M_LOAD && (ld_done || (acc && m_ptr == 0)))
          m_mode = M_RUN;
      end
      // CPU is released only after a full cycle spent in RUN
      m_hold = (old_mode == M_RUN && m_mode == M_RUN) ? 0 : 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_in();
    ld_start = 0; ld_valid = 0; ld_data = 0; ld_done = 0;
    adress = 0; oe = 0; we = 0; wdata = 0;
  endtask

  task automatic do_reset();
    idle_in();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic chk_model();
    int exp_rd;
    exp_rd = (m_mode == M_RUN && oe) ? m_mem[adress] : 0;
    chk("m_rdata", int'(rdata), exp_rd);
    chk("m_ready", int'(ld_ready), (m_mode == M_LOAD) ? 1 : 0);
    chk("m_hold", int'(cpu_hold), m_hold);
    chk("m_ptr", int'(ld_ptr), m_ptr);
    chk("m_err", int'(busy_err), m_err);
  endtask

  typedef struct {
    bit       start;
    bit       valid;
    bit [7:0] data;
    bit       done;
    bit [5:0] adr;
    bit       oe;
    bit       we;
    bit [7:0] wd;
    bit [7:0] e_rd;
    bit       e_rdy;
    bit       e_hold;
    bit [5:0] e_ptr;
    bit       e_err;
  } vec_t;

  function automatic vec_t V(bit st, bit va, bit [7:0] d, bit dn, bit [5:0] a,
                             bit o, bit w, bit [7:0] wd, bit [7:0] erd,
                             bit erdy, bit eh, bit [5:0] ep, bit ee);
    vec_t v;
    v.start = st; v.valid = va; v.data = d; v.done = dn; v.adr = a;
    v.oe = o; v.we = w; v.wd = wd; v.e_rd = erd; v.e_rdy = erdy;
    v.e_hold = eh; v.e_ptr = ep; v.e_err = ee;
    return v;
  endfunction

  vec_t tbl [20];

  initial begin
    // start va data dn adr oe we wd | rd rdy hold ptr err
    tbl[0]  = V(1, 0, 8'h00, 0, 6'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0);
    tbl[1]  = V(0, 1, 8'h11, 0, 6'h00, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
    tbl[2]  = V(0, 0, 8'h00, 0, 6'h00, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0);
    tbl[3]  = V(0, 1, 8'h22, 0, 6'h00, 0, 0, 8'h00, 8'h00, 1, 1, 1, 0);
    tbl[4]  = V(0, 0, 8'h00, 0, 6'h00, 0, 0, 8'h00, 8'h00, 1, 1, 2, 0);
    tbl[5]  = V(0, 1, 8'h33, 1, 6'h00, 0, 0, 8'h00, 8'h00, 1, 1, 2, 0);
    tbl[6]  = V(0, 0, 8'h00, 0, 6'h03, 1, 0, 8'h00, 8'h00, 0, 1, 3, 0);
    tbl[7]  = V(0, 0, 8'h00, 0, 6'h02, 1, 0, 8'h00, 8'h33, 0, 0, 3, 0);
    tbl[8]  = V(0, 0, 8'h00, 0, 6'h10, 0, 1, 8'h5C, 8'h00, 0, 0, 3, 0);
    tbl[9]  = V(0, 0, 8'h00, 0, 6'h10, 1, 0, 8'h00, 8'h5C, 0, 0, 3, 0);
    tbl[10] = V(0, 0, 8'h00, 0, 6'h10, 1, 1, 8'h77, 8'h5C, 0, 0, 3, 0);
    tbl[11] = V(0, 0, 8'h00, 0, 6'h10, 1, 0, 8'h00, 8'h77, 0, 0, 3, 0);
    tbl[12] = V(0, 0, 8'h00, 0, 6'h00, 1, 0, 8'h00, 8'h11, 0, 0, 3, 0);
    tbl[13] = V(1, 0, 8'h00, 0, 6'h00, 0, 0, 8'h00, 8'h00, 0, 0, 3, 0);
    tbl[14] = V(0, 0, 8'h00, 0, 6'h00, 0, 0, 8'h00, 8'h00, 1, 1, 0, 0);
    tbl[15] = V(0, 0, 8'h00, 0, 6'h05, 0, 1, 8'hFF, 8'h00, 1, 1, 0, 0);
    tbl[16] = V(0, 0, 8'h00, 0, 6'h05, 1, 0, 8'h00, 8'h00, 1, 1, 0, 1);
    tbl[17] = V(0, 0, 8'h00, 1, 6'h00, 0, 0, 8'h00, 8'h00, 1, 1, 0, 1);
    tbl[18] = V(0, 0, 8'h00, 0, 6'h05, 1, 0, 8'h00, 8'h00, 0, 1, 0, 1);
    tbl[19] = V(0, 0, 8'h00, 0, 6'h01, 1, 0, 8'h00, 8'h22, 0, 0, 0, 1);

    rst_n = 0;
    idle_in();
    @(negedge clk);

    // Reset values, then every word reads zero in RUN
    do_reset();
    #1;
    chk("rst_hold", int'(cpu_hold), 1);
    chk("rst_ready", int'(ld_ready), 0);
    chk("rst_ptr", int'(ld_ptr), 0);
    chk("rst_err", int'(busy_err), 0);
    @(negedge clk);
    ld_start = 1; tick(); ld_start = 0;
    ld_done = 1; tick(); ld_done = 0;
    for (int a = 0; a < DEPTH; a++) begin
      adress = 6'(a); oe = 1;
      #1;
      chk("rst_mem", int'(rdata), 0);
      tick();
    end
    oe = 0;

    // Full 64-byte load with valid held high
    ld_start = 1; tick(); ld_start = 0;
    for (int i = 0; i < DEPTH; i++) begin
      ld_valid = 1; ld_data = 8'(i) ^ 8'hA5;
      #1;
      chk("full_ptr", int'(ld_ptr), i);
      chk("full_ready", int'(ld_ready), 1);
      tick();
    end
    #1;
    chk("full_run_ready", int'(ld_ready), 0);
    chk("full_wrap_ptr", int'(ld_ptr), 0);
    chk("full_hold_lag", int'(cpu_hold), 1);
    tick();
    ld_valid = 0;
    #1;
    chk("full_hold_fall", int'(cpu_hold), 0);
    oe = 1; adress = 6'h00; #1; chk("full_rd00", int'(rdata), 8'hA5);
    adress = 6'h2A; #1; chk("full_rd2A", int'(rdata), 8'h8F);
    adress = 6'h3F; #1; chk("full_rd3F", int'(rdata), 8'h9A);
    oe = 0;
    @(negedge clk);

    // Directed table: early done, CPU access, reload, illegal access
    do_reset();
    foreach (tbl[i]) begin
      ld_start = tbl[i].start; ld_valid = tbl[i].valid;
      ld_data = tbl[i].data; ld_done = tbl[i].done;
      adress = tbl[i].adr; oe = tbl[i].oe; we = tbl[i].we;
      wdata = tbl[i].wd;
      #1;
      chk($sformatf("t%0d_rdata", i), int'(rdata), int'(tbl[i].e_rd));
      chk($sformatf("t%0d_ready", i), int'(ld_ready), int'(tbl[i].e_rdy));
      chk($sformatf("t%0d_hold", i), int'(cpu_hold), int'(tbl[i].e_hold));
      chk($sformatf("t%0d_ptr", i), int'(ld_ptr), int'(tbl[i].e_ptr));
      chk($sformatf("t%0d_err", i), int'(busy_err), int'(tbl[i].e_err));
      tick();
    end
    idle_in();
    do_reset();
    #1;
    chk("err_cleared", int'(busy_err), 0);
    @(negedge clk);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      idle_in();
      rst_n    = ($urandom_range(0, 299) != 0);
      ld_start = ($urandom_range(0, 39) == 0);
      ld_done  = ($urandom_range(0, 29) == 0);
      ld_valid = $urandom_range(0, 1) != 0;
      ld_data  = 8'($urandom);
      adress   = 6'($urandom);
      wdata    = 8'($urandom);
      if (m_mode == M_RUN || $urandom_range(0, 99) == 0) begin
        oe = $urandom_range(0, 2) == 0;
        we = $urandom_range(0, 3) == 0;
      end
      #1;
      chk_model();
      tick();
    end
    idle_in();
    rst_n = 1;
    #1;
    chk_model();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mcpu_mem_responder.md
Name: mcpu_mem_responder

Overview:
Memory-side target for the MCPU external bus. It implements the 64x8 RAM that answers the CPU's adress/oe/we/dataout strobes with datain. It also provides a byte-parallel program loader with a valid/ready handshake, which preloads the RAM while the CPU is held in reset. It sits beside the CPU at top level: its rdata feeds the CPU's datain, and its cpu_hold is ANDed into the CPU reset.

Parameters:
AW, 6, address width; depth = 2**AW words
DW, 8, data word width

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
adress  input  AW  CPU bus address
oe  input  1  CPU read strobe
we  input  1  CPU write strobe
wdata  input  DW  CPU write data (CPU dataout)
rdata  output  DW  read data to CPU datain
ld_start  input  1  pulse: begin program load at address 0
ld_valid  input  1  loader byte valid
ld_data  input  DW  loader byte
ld_done  input  1  pulse: end load early, release CPU
ld_ready  output  1  responder accepts loader byte this cycle
cpu_hold  output  1  high = CPU must be held in reset
ld_ptr  output  AW  current load address
busy_err  output  1  sticky: CPU strobe seen while not in RUN

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: state=IDLE, cpu_hold=1, ld_ready=0, ld_ptr=0, busy_err=0. All 2**AW memory words are cleared to 0.
- State machine IDLE / LOAD / RUN:
  - IDLE: ld_start -> LOAD with ld_ptr=0.
  - LOAD: ld_done -> RUN. A write of the last word (ld_ptr==2**AW-1 accepted) -> RUN, and ld_ptr wraps to 0.
  - RUN: ld_start -> LOAD with ld_ptr=0.
  - ld_start takes priority over ld_done in any state.
- cpu_hold: registered. It is 1 in IDLE and LOAD and 0 in RUN. It deasserts on the first edge after entering RUN.
- ld_ready: combinational, equal to (state==LOAD).
- Load handshake: on an edge with ld_valid & ld_ready, mem[ld_ptr] <= ld_data and ld_ptr increments.
  - A byte accepted on the same edge as ld_done is still written; then the state moves to RUN.
  - ld_valid outside LOAD is ignored.
- ld_start during LOAD restarts ld_ptr at 0. Earlier writes are kept.
- CPU bus, active only in RUN:
  - Read is combinational: rdata = oe ? mem[adress] : 0. Latency is 0 cycles because the CPU samples datain at the edge ending the oe cycle.
  - Write is synchronous: mem[adress] <= wdata on the edge when we=1.
  - oe & we together: the write happens at the edge. During that cycle rdata shows the pre-write content.
- Outside RUN: rdata=0 and we is ignored. Any oe or we sets busy_err, which clears only on reset.
- Reset mid-load or mid-run: everything returns to the reset values and memory is cleared.
- Address arithmetic: ld_ptr is AW bits, unsigned, and wraps modulo 2**AW.

Test Plan:
1. Reset: hold rst_n=0 for 2 clocks -> cpu_hold=1, ld_ready=0, ld_ptr=0, busy_err=0. With state forced to RUN via ld_start+ld_done, reading addresses 0..63 returns 0x00.
2. Full load: ld_start, then 64 bytes (data=addr^0xA5) with ld_valid held 1 -> ld_ptr counts 0..63. The state moves to RUN after byte 63 is accepted and cpu_hold falls on the next edge. oe reads at addr 0x00, 0x2A, 0x3F return 0xA5, 0x8F, 0x9A.
3. Early done with gapped valid: ld_start, 3 bytes 0x11,0x22,0x33 with idle cycles between, ld_done with the third byte -> all three are written. State=RUN, ld_ptr=3, mem[3]=0x00.
4. CPU write/read in RUN: we=1, adress=0x10, wdata=0x5C, then oe at 0x10 -> rdata=0x5C. With oe&we together at 0x10 and wdata=0x77 -> rdata=0x5C in that cycle and 0x77 on the following oe cycle.
5. Reload: ld_start in RUN -> cpu_hold=1 the next cycle, ld_ready=1, ld_ptr=0. Bytes written in the prior run are preserved except the overwritten ones.
6. Illegal access: we=1 at adress 0x05 with wdata=0xFF while in LOAD -> mem[5] is unchanged, rdata=0, busy_err=1. busy_err stays set until rst_n=0.
